mc_mem_arbiter: RTL and testbench

Shares the multi-cycle CPU's single-port unified memory between two requesters: the CPU datapath (instruction fetch and load/store) and a debug/dump master that reads and writes memory while the CPU runs. Arbitration is fixed-priority to the CPU, with an anti-starvation promotion for the debug port. Each access is sequenced through a fixed-latency synchronous memory and answered with a one-cycle ready pulse. The block sits between the CPU/debug masters and the memory instance.

---
 rtl/mc_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mc_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between the CPU datapath and a
// debug master. The CPU has fixed priority; a debug request is promoted once it has waited long enough.
module mc_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ready,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_ready,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [1:0]        o_grant,
    output logic [7:0]        o_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // The starvation counter saturates at 15, so a threshold above that never promotes debug.
    localparam logic [4:0] LP_STARVE_LIM = (STARVE_MAX > 15) ? 5'd16 : 5'(STARVE_MAX);
    localparam logic [3:0] LP_LAT        = 4'(MEM_LAT);

    state_t              r_state;
    logic [3:0]          r_lat_cnt;
    logic [3:0]          r_starve;
    logic                r_sel_dbg;
    logic                r_we;
    logic [1:0]          r_grant;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cpu_ready;
    logic                r_dbg_ready;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_dbg_rdata;

    logic                w_any_req;
    logic                w_starved;
    logic                w_dbg_wins;

    assign w_any_req  = i_cpu_req | i_dbg_req;
    assign w_starved  = ({1'b0, r_starve} >= LP_STARVE_LIM);
    assign w_dbg_wins = i_dbg_req & (~i_cpu_req | w_starved);

    // Counts every cycle a debug request is pending without owning the memory.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve <= '0;
        end else if (r_state == ST_IDLE && (w_dbg_wins || !i_dbg_req)) begin
            r_starve <= '0;
        end else if (i_dbg_req && r_grant != 2'b10 && r_starve != 4'hF) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_lat_cnt   <= '0;
            r_sel_dbg   <= 1'b0;
            r_we        <= 1'b0;
            r_grant     <= 2'b00;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_ready <= 1'b0;
            r_dbg_ready <= 1'b0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_sel_dbg   <= w_dbg_wins;
                        r_grant     <= w_dbg_wins ? 2'b10 : 2'b01;
                        r_we        <= w_dbg_wins ? i_dbg_we : i_cpu_we;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_dbg_wins ? i_dbg_we    : i_cpu_we;
                        r_mem_addr  <= w_dbg_wins ? i_dbg_addr  : i_cpu_addr;
                        r_mem_wdata <= w_dbg_wins ? i_dbg_wdata : i_cpu_wdata;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_mem_en    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_lat_cnt   <= LP_LAT;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_lat_cnt <= r_lat_cnt - 4'd1;
                    if (r_lat_cnt == 4'd1) begin
                        if (r_sel_dbg) begin
                            r_dbg_rdata <= r_we ? '0 : i_mem_rdata;
                            r_dbg_ready <= 1'b1;
                        end else begin
                            r_cpu_rdata <= r_we ? '0 : i_mem_rdata;
                            r_cpu_ready <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_cpu_ready <= 1'b0;
                    r_dbg_ready <= 1'b0;
                    r_grant     <= 2'b00;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cpu_ready = r_cpu_ready;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_dbg_ready = r_dbg_ready;
    assign o_dbg_rdata = r_dbg_rdata;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_grant     = r_grant;
    assign o_state     = {6'd0, r_state};

endmodule

// File: tb/tb_mc_mem_arbiter.sv
// Bench for mc_mem_arbiter: directed scenarios on MEM_LAT=1 and MEM_LAT=3 instances,
// then random two-master traffic against a transaction-level reference model.
module tb_mc_mem_arbiter;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned LAT  = 1;
    localparam int unsigned LAT3 = 3;
    localparam int unsigned SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0]   cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic          cpu_ready, dbg_ready, mem_en, mem_we;
    logic [31:0]   cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]    grant;
    logic [7:0]    state;

    logic          c3_req, c3_we, d3_req, d3_we;
    logic [31:0]   c3_addr, c3_wdata, d3_addr, d3_wdata;
    logic          c3_ready, d3_ready, m3_en, m3_we;
    logic [31:0]   c3_rdata, d3_rdata, m3_addr, m3_wdata, m3_rdata;
    logic [1:0]    grant3;
    logic [7:0]    state3;

    int unsigned   total = 0;
    int unsigned   bad = 0;

    always #5 clk = ~clk;

    mc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_ready(cpu_ready), .o_cpu_rdata(cpu_rdata),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
        .o_dbg_ready(dbg_ready), .o_dbg_rdata(dbg_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_grant(grant), .o_state(state)
    );

    mc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT3), .STARVE_MAX(SMAX)) u_dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(c3_req), .i_cpu_we(c3_we), .i_cpu_addr(c3_addr), .i_cpu_wdata(c3_wdata),
        .o_cpu_ready(c3_ready), .o_cpu_rdata(c3_rdata),
        .i_dbg_req(d3_req), .i_dbg_we(d3_we), .i_dbg_addr(d3_addr), .i_dbg_wdata(d3_wdata),
        .o_dbg_ready(d3_ready), .o_dbg_rdata(d3_rdata),
        .o_mem_en(m3_en), .o_mem_we(m3_we), .o_mem_addr(m3_addr), .o_mem_wdata(m3_wdata),
        .i_mem_rdata(m3_rdata), .o_grant(grant3), .o_state(state3)
    );

    function automatic logic [31:0] mem_init(int unsigned i);
        logic [31:0] v;
        v = i;
        return (i == 64) ? 32'hDEADBEEF : (32'hA5000000 | (v << 8) | v);
    endfunction

    // Latency-1 memory for u_dut: read data is only valid in the cycle after the strobe.
    logic [31:0] env_mem [0:127];
    always @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 128; i++) env_mem[i] <= mem_init(i);
            mem_rdata <= 32'hBAD00000;
        end else begin
            if (mem_en && mem_we) env_mem[mem_addr[8:2]] <= mem_wdata;
            mem_rdata <= (mem_en && !mem_we) ? env_mem[mem_addr[8:2]] : 32'hBAD00000;
        end
    end

    // Latency-3 memory for u_dut3: returns addr ^ 0x5A5A0000 exactly three cycles after the strobe.
    logic [31:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= m3_en ? (m3_addr ^ 32'h5A5A0000) : 32'hBAD00000;
        p2 <= p1;
        p3 <= p2;
    end
    assign m3_rdata = p3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1; c3_req = 1'b1;
        repeat (3) tick();
        total++; if (state !== 8'h00) begin bad++; $display("FAIL reset_state: got %h want 00", state); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
        total++; if ({cpu_ready, dbg_ready, mem_en, mem_we} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes: got %b want 0000", {cpu_ready, dbg_ready, mem_en, mem_we}); end
        total++; if ({mem_addr, mem_wdata} !== 64'd0) begin
            bad++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata}); end
        total++; if ({cpu_rdata, dbg_rdata} !== 64'd0) begin
            bad++; $display("FAIL reset_rdata: got %h want 0", {cpu_rdata, dbg_rdata}); end
        total++; if ({state3, grant3} !== 10'd0) begin
            bad++; $display("FAIL reset_dut3: got %h want 0", {state3, grant3}); end
        rst = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0; c3_req = 1'b0;
        tick();
        total++; if (state !== 8'h00) begin bad++; $display("FAIL idle_no_req: got %h want 00", state); end
    endtask

    task automatic test_cpu_read();
        logic [1:0] exp_st;
        cpu_we = 1'b0; cpu_addr = 32'h100; cpu_wdata = 32'h0; cpu_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) cpu_req = 1'b0;
            exp_st = (k == 4) ? 2'd0 : 2'(k);
            total++; if (state !== {6'd0, exp_st}) begin bad++; $display("FAIL cpu_rd_state k=%0d: got %h want %h", k, state, exp_st); end
            total++; if (mem_en !== (k == 1)) begin bad++; $display("FAIL cpu_rd_en k=%0d: got %b", k, mem_en); end
            total++; if (cpu_ready !== (k == 3)) begin bad++; $display("FAIL cpu_rd_ready k=%0d: got %b", k, cpu_ready); end
            if (k == 1) begin
                total++; if (mem_addr !== 32'h100 || mem_we !== 1'b0 || grant !== 2'b01) begin
                    bad++; $display("FAIL cpu_rd_access: got addr=%h we=%b grant=%b want 100/0/01", mem_addr, mem_we, grant); end
            end
            if (k >= 3) begin
                total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_rd_data k=%0d: got %h want deadbeef", k, cpu_rdata); end
            end
        end
    endtask

    task automatic test_dbg_wr_rd();
        dbg_we = 1'b1; dbg_addr = 32'h104; dbg_wdata = 32'h12345678; dbg_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 4) dbg_we = 1'b0;
            if (k == 8) dbg_req = 1'b0;
            total++; if (mem_en !== (k == 1 || k == 5)) begin bad++; $display("FAIL dbg_en k=%0d: got %b", k, mem_en); end
            if (k == 1 || k == 5) begin
                total++; if (mem_we !== (k == 1) || mem_addr !== 32'h104 || mem_wdata !== 32'h12345678 || grant !== 2'b10) begin
                    bad++; $display("FAIL dbg_access k=%0d: got we=%b addr=%h wd=%h grant=%b", k, mem_we, mem_addr, mem_wdata, grant); end
            end
            total++; if (dbg_ready !== (k == 3 || k == 7)) begin bad++; $display("FAIL dbg_ready k=%0d: got %b", k, dbg_ready); end
            total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL dbg_cpu_quiet k=%0d: got %b want 0", k, cpu_ready); end
            if (k == 3) begin
                total++; if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL dbg_wr_rdata: got %h want 0", dbg_rdata); end
            end
            if (k == 7) begin
                total++; if (dbg_rdata !== 32'h12345678) begin bad++; $display("FAIL dbg_rd_rdata: got %h want 12345678", dbg_rdata); end
            end
        end
    endtask

    task automatic test_both();
        logic [1:0] exp_g;
        cpu_we = 1'b0; cpu_addr = 32'h10; dbg_we = 1'b0; dbg_addr = 32'h20;
        cpu_req = 1'b1; dbg_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 4) cpu_req = 1'b0;
            if (k == 8) dbg_req = 1'b0;
            exp_g = (k <= 3) ? 2'b01 : (k >= 5 && k <= 7) ? 2'b10 : 2'b00;
            total++; if (grant !== exp_g) begin bad++; $display("FAIL both_grant k=%0d: got %b want %b", k, grant, exp_g); end
            if (k == 1 || k == 5) begin
                total++; if (mem_addr !== ((k == 1) ? 32'h10 : 32'h20)) begin bad++; $display("FAIL both_addr k=%0d: got %h", k, mem_addr); end
            end
            total++; if ({cpu_ready, dbg_ready} !== {k == 3, k == 7}) begin
                bad++; $display("FAIL both_ready k=%0d: got %b%b", k, cpu_ready, dbg_ready); end
            if (k == 3) begin
                total++; if (cpu_rdata !== mem_init(4)) begin bad++; $display("FAIL both_cpu_data: got %h want %h", cpu_rdata, mem_init(4)); end
            end
            if (k == 7) begin
                total++; if (dbg_rdata !== mem_init(8)) begin bad++; $display("FAIL both_dbg_data: got %h want %h", dbg_rdata, mem_init(8)); end
            end
        end
    endtask

    task automatic test_starvation();
        logic [1:0] exp_g;
        cpu_we = 1'b0; cpu_addr = 32'h30; dbg_we = 1'b0; dbg_addr = 32'h40;
        cpu_req = 1'b1; dbg_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 4) cpu_addr = 32'h34;
            if (k == 8) dbg_req = 1'b0;
            if (k == 12) cpu_req = 1'b0;
            exp_g = (k <= 3 || (k >= 9 && k <= 11)) ? 2'b01 : (k >= 5 && k <= 7) ? 2'b10 : 2'b00;
            total++; if (grant !== exp_g) begin bad++; $display("FAIL starve_grant k=%0d: got %b want %b", k, grant, exp_g); end
            total++; if ({cpu_ready, dbg_ready} !== {k == 3 || k == 11, k == 7}) begin
                bad++; $display("FAIL starve_ready k=%0d: got %b%b", k, cpu_ready, dbg_ready); end
            if (k == 3 || k == 11) begin
                total++; if (cpu_rdata !== mem_init((k == 3) ? 12 : 13)) begin bad++; $display("FAIL starve_cpu_data k=%0d: got %h", k, cpu_rdata); end
            end
            if (k == 7) begin
                total++; if (dbg_rdata !== mem_init(16)) begin bad++; $display("FAIL starve_dbg_data: got %h want %h", dbg_rdata, mem_init(16)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        cpu_we = 1'b0; cpu_addr = 32'h100; cpu_req = 1'b1;
        tick(); tick();
        total++; if (state !== 8'h02) begin bad++; $display("FAIL rstmid_wait: got %h want 02", state); end
        rst = 1'b1;
        tick();
        rst = 1'b0; cpu_req = 1'b0;
        total++; if ({state, grant} !== 10'd0) begin bad++; $display("FAIL rstmid_state: got %h want 0", {state, grant}); end
        total++; if ({cpu_ready, dbg_ready, mem_en, mem_we} !== 4'd0) begin
            bad++; $display("FAIL rstmid_strobes: got %b want 0000", {cpu_ready, dbg_ready, mem_en, mem_we}); end
        total++; if ({cpu_rdata, dbg_rdata} !== 64'd0) begin bad++; $display("FAIL rstmid_rdata: got %h want 0", {cpu_rdata, dbg_rdata}); end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (cpu_ready !== 1'b0 || state !== 8'h00) begin
                bad++; $display("FAIL rstmid_no_ready k=%0d: got ready=%b state=%h", k, cpu_ready, state); end
        end
    endtask

    task automatic test_latency3();
        logic [7:0] exp_st;
        c3_we = 1'b0; c3_addr = 32'h40; c3_wdata = 32'h0; c3_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 6) c3_req = 1'b0;
            exp_st = (k == 1) ? 8'h01 : (k <= 4) ? 8'h02 : (k == 5) ? 8'h03 : 8'h00;
            total++; if (state3 !== exp_st) begin bad++; $display("FAIL lat3_state k=%0d: got %h want %h", k, state3, exp_st); end
            total++; if (m3_en !== (k == 1)) begin bad++; $display("FAIL lat3_en k=%0d: got %b", k, m3_en); end
            total++; if (c3_ready !== (k == 5)) begin bad++; $display("FAIL lat3_ready k=%0d: got %b", k, c3_ready); end
            if (k == 5) begin
                total++; if (c3_rdata !== 32'h5A5A0040) begin bad++; $display("FAIL lat3_data: got %h want 5a5a0040", c3_rdata); end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [0:127];
        int unsigned idle_at, en_at, rdy_at, starve, owner, n_c, n_d, seen_c, seen_d;
        int unsigned t_end;
        logic        lw, in_txn, exp_en, exp_cr, exp_dr, is_idle, win_dbg, c_done, d_done;
        logic [31:0] la, lwd, exp_rd, last_c, last_d;
        logic [1:0]  exp_g;
        for (int unsigned i = 0; i < 128; i++) ref_mem[i] = mem_init(i);
        idle_at = 0; en_at = 0; rdy_at = 0; owner = 0; starve = 0;
        n_c = 0; n_d = 0; seen_c = 0; seen_d = 0; t_end = 600;
        lw = 1'b0; la = '0; lwd = '0; exp_rd = '0; last_c = '0; last_d = '0;
        c_done = 1'b0; d_done = 1'b0;
        for (int unsigned t = 0; t < t_end + 20; t++) begin
            in_txn = (owner != 0) && (t >= en_at) && (t <= rdy_at);
            exp_en = (owner != 0) && (t == en_at);
            exp_cr = (owner == 1) && (t == rdy_at);
            exp_dr = (owner == 2) && (t == rdy_at);
            exp_g  = in_txn ? owner[1:0] : 2'b00;
            if (exp_cr) last_c = exp_rd;
            if (exp_dr) last_d = exp_rd;
            if (cpu_ready === 1'b1) seen_c++;
            if (dbg_ready === 1'b1) seen_d++;
            total++; if (mem_en !== exp_en) begin bad++; $display("FAIL rnd_en t=%0d: got %b want %b", t, mem_en, exp_en); end
            if (exp_en) begin
                total++; if ({mem_we, mem_addr, mem_wdata} !== {lw, la, lwd}) begin
                    bad++; $display("FAIL rnd_access t=%0d: got %b/%h/%h want %b/%h/%h", t, mem_we, mem_addr, mem_wdata, lw, la, lwd); end
            end
            total++; if (cpu_ready !== exp_cr) begin bad++; $display("FAIL rnd_cpu_ready t=%0d: got %b want %b", t, cpu_ready, exp_cr); end
            total++; if (dbg_ready !== exp_dr) begin bad++; $display("FAIL rnd_dbg_ready t=%0d: got %b want %b", t, dbg_ready, exp_dr); end
            total++; if (cpu_rdata !== last_c) begin bad++; $display("FAIL rnd_cpu_rdata t=%0d: got %h want %h", t, cpu_rdata, last_c); end
            total++; if (dbg_rdata !== last_d) begin bad++; $display("FAIL rnd_dbg_rdata t=%0d: got %h want %h", t, dbg_rdata, last_d); end
            total++; if (grant !== exp_g) begin bad++; $display("FAIL rnd_grant t=%0d: got %b want %b", t, grant, exp_g); end

            if (c_done) cpu_req = (t < t_end) && ($urandom_range(0, 1) == 1);
            else if (!cpu_req) cpu_req = (t < t_end) && ($urandom_range(0, 2) == 0);
            if (c_done || $urandom_range(0, 2) == 0) begin
                cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom_range(0, 127) << 2; cpu_wdata = $urandom();
            end
            if (d_done) dbg_req = (t < t_end) && ($urandom_range(0, 1) == 1);
            else if (!dbg_req) dbg_req = (t < t_end) && ($urandom_range(0, 2) == 0);
            if (d_done || $urandom_range(0, 2) == 0) begin
                dbg_we = 1'($urandom_range(0, 1)); dbg_addr = $urandom_range(0, 127) << 2; dbg_wdata = $urandom();
            end

            is_idle = (t == idle_at);
            win_dbg = dbg_req && (!cpu_req || starve >= SMAX);
            if (is_idle && (cpu_req || dbg_req)) begin
                owner  = win_dbg ? 2 : 1;
                lw     = win_dbg ? dbg_we    : cpu_we;
                la     = win_dbg ? dbg_addr  : cpu_addr;
                lwd    = win_dbg ? dbg_wdata : cpu_wdata;
                exp_rd = lw ? 32'h0 : ref_mem[la[8:2]];
                if (lw) ref_mem[la[8:2]] = lwd;
                en_at = t + 1; rdy_at = t + 2 + LAT; idle_at = t + 3 + LAT;
                if (win_dbg) n_d++; else n_c++;
            end else if (is_idle) begin
                idle_at = t + 1;
            end
            if (is_idle && (!dbg_req || win_dbg)) starve = 0;
            else if (dbg_req && exp_g != 2'b10 && starve < 15) starve++;
            c_done = exp_cr; d_done = exp_dr;
            tick();
        end
        total++; if (seen_c != n_c || seen_d != n_d) begin
            bad++; $display("FAIL rnd_completions: got cpu=%0d dbg=%0d want cpu=%0d dbg=%0d", seen_c, seen_d, n_c, n_d); end
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        c3_req = 1'b0; c3_we = 1'b0; c3_addr = '0; c3_wdata = '0;
        d3_req = 1'b0; d3_we = 1'b0; d3_addr = '0; d3_wdata = '0;
        test_reset();
        test_cpu_read();
        test_dbg_wr_rd();
        test_both();
        test_starvation();
        test_reset_mid();
        test_latency3();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
